if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage that owns the program counter. Each cycle it drives a word address into the combinational instruction ROM and registers the returned instruction and its PC into the IF/ID pipeline register. It presents that register to decode through a valid/ready handshake. It accepts control-flow redirects from downstream, flushing the in-flight fetch.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `imem_addr`  out  32: fetch byte address to ROM; combinationally equal to `pc`.
- `imem_instr`  in  32: ROM read data, combinational from `imem_addr`.
- `redirect_valid`  in  1: taken branch/jump/trap this cycle.
- `redirect_pc`  in  32: redirect target byte address.
- `id_valid`  out  1: IF/ID register holds a valid instruction.
- `id_ready`  in  1: decode accepts the instruction this cycle.
- `id_pc`  out  32: PC of `id_instr`.
- `id_instr`  out  32: fetched instruction.
- `misalign_err`  out  1: one-cycle pulse on a misaligned redirect (see Configuration).

## Operation
- Internal `pc` register (32 b); `imem_addr = pc`.
- `load = !id_valid || id_ready`, i.e. the IF/ID register is empty or being drained.
- Per-cycle priority, evaluated at the rising edge:
  1. `redirect_valid`: `pc <= target`, `id_valid <= 0` (flush), `id_pc`/`id_instr` hold. Fires regardless of `id_ready`.
  2. else `load`: `id_pc <= pc`, `id_instr <= imem_instr`, `id_valid <= 1`, `pc <= pc + 4`.
  3. else (stall, `id_valid && !id_ready`): all registers hold.
- Implicit two-state output FSM:
  - EMPTY → FULL on load.
  - FULL → FULL on load with `id_ready`.
  - FULL → FULL holding on stall.
  - any → EMPTY on redirect.
- Arithmetic: `pc + 4` is modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000 with no flag.
- While `id_valid` is high and `id_ready` is low, `id_pc` and `id_instr` must be stable.
- Reset values (asynchronous):
  - `pc = RESET_PC`
  - `id_valid = 0`
  - `id_pc = 0`
  - `id_instr = 32'h0000_0013` (NOP)
  - `misalign_err = 0`

## Timing
- Fetch latency: 1 cycle from `pc` to `id_valid`/`id_instr`.
- Throughput: 1 instruction per cycle while `id_ready` stays high.
- First `id_valid` occurs at the first rising edge after `rst_n` deasserts, carrying PC `RESET_PC`.
- Redirect penalty is 1 bubble:
  - Cycle N: redirect asserted.
  - Cycle N+1: `id_valid` = 0 and `pc` = target.
  - Cycle N+2: `id_valid` = 1 with `id_pc` = target.
- Redirect together with `id_ready` on a FULL register: the held instruction counts as consumed and no new one is loaded.
- Reset asserted mid-operation: all state returns to reset values immediately, without waiting for a clock edge. Pending redirects are discarded.
- There are no combinational paths from `id_ready` or `redirect_*` to any output.

## Configuration
- `IF_MISALIGN_CHK_EN`, when defined:
  - A redirect with `redirect_pc[1:0] != 0` is still taken, with the target forced to `{redirect_pc[31:2], 2'b00}`.
  - `misalign_err` is registered high for exactly one cycle (cycle N+1).
- When undefined:
  - target = `redirect_pc` unmodified. The low bits are carried in `pc`, but the ROM ignores them.
  - `misalign_err` is tied 0.

## Test plan
- Reset, release, `id_ready`=1 → `id_pc`/`id_instr` = 0/00100093, 4/00200113, 8/00300193 on consecutive cycles; nothing is valid during reset.
- `id_valid`=1 at pc 4, hold `id_ready`=0 for 3 cycles → `id_pc`=4 and `id_instr`=00200113 stable; after release, next is 8/00300193 with no duplicate or skip.
- Redirect to 0x10 while stalled at pc 8 → next cycle `id_valid`=0; following cycle `id_pc`=0x10, `id_instr`=00500293.
- `RESET_PC`=32'hFFFF_FFF8, free-run → `id_pc` sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- With `IF_MISALIGN_CHK_EN`, redirect to 0x0E → `misalign_err` pulses 1 cycle, next `id_pc`=0x0C; without the macro, `misalign_err` stays 0 and `id_pc`=0x0E.
- Assert `rst_n`=0 asynchronously mid-stream (between edges) → `id_valid`=0 and `id_instr`=00000013 immediately; after release, fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/if_stage.sv
// if_stage: instruction fetch owning the PC; registers ROM data into the IF/ID register. Optional macro IF_MISALIGN_CHK_EN.
// Latency: 1 cycle from pc to id_valid/id_instr; one bubble after a redirect.
// Backpressure: id_valid && !id_ready freezes pc and IF/ID; a redirect always wins and flushes.
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_pc,
   output logic [31:0] id_instr,
   output logic        misalign_err
);

   // Instruction presented while nothing has been fetched yet (addi x0,x0,0).
   localparam logic [31:0] NOP = 32'h0000_0013;

   // Occupancy of the IF/ID register; FULL is exactly id_valid.
   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] pc_seq;
   logic [31:0] target;
   logic        load;

   // The ROM is addressed straight from the PC register, so no input reaches it combinationally.
   assign imem_addr = pc;

   // The register can take a new word when empty or when decode is draining it.
   assign load = (state == EMPTY) || id_ready;

   // Sequential successor; 32-bit add wraps silently at the top of the address space.
   assign pc_seq = pc + 32'd4;

   // id_valid comes directly from the state flop.
   assign id_valid = (state == FULL);

`ifdef IF_MISALIGN_CHK_EN
   logic redirect_misaligned;

   // Misaligned targets are still taken, rounded down to the containing word.
   assign target              = {redirect_pc[31:2], 2'b00};
   assign redirect_misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);

   // One-cycle error pulse in the cycle after the offending redirect.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         misalign_err <= 1'b0;
      end else begin
         misalign_err <= redirect_misaligned;
      end
   end
`else
   // Targets pass through untouched; the ROM ignores the two low address bits.
   assign target       = redirect_pc;
   assign misalign_err = 1'b0;
`endif

   // PC and IF/ID register update: redirect flushes, otherwise fetch when the slot frees, else hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= EMPTY;
         pc       <= RESET_PC;
         id_pc    <= 32'h0000_0000;
         id_instr <= NOP;
      end else if (redirect_valid) begin
         // Flush: id_pc/id_instr keep their last contents but are no longer valid.
         state <= EMPTY;
         pc    <= target;
      end else begin
         case (state)
            EMPTY: begin
               state    <= FULL;
               id_pc    <= pc;
               id_instr <= imem_instr;
               pc       <= pc_seq;
            end
            FULL: begin
               if (load) begin
                  id_pc    <= pc;
                  id_instr <= imem_instr;
                  pc       <= pc_seq;
               end
            end
            default: begin
               state <= EMPTY;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Randomized scoreboard bench for if_stage with an in-bench ROM and a cycle-level reference model.
// Stimulus pushes the expected per-cycle IF/ID view; an independent monitor pops and compares.
// A second instance with RESET_PC near the top of memory exercises PC wraparound.
module tb_if_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [31:0] imem_addr, imem_instr;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        id_valid;
   logic        id_ready = 1'b0;
   logic [31:0] id_pc, id_instr;
   logic        misalign_err;

   logic [31:0] w_imem_addr, w_imem_instr, w_id_pc, w_id_instr;
   logic        w_id_valid, w_misalign_err;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   // ROM contents: word k holds "addi x(k+1), x0, k+1"; low two address bits are ignored.
   function automatic logic [31:0] rom(input logic [31:0] a);
      logic [11:0] k;
      k = a[13:2] + 12'd1;
      return {k, 8'd0, k[4:0], 7'h13};
   endfunction

   assign imem_instr   = rom(imem_addr);
   assign w_imem_instr = rom(w_imem_addr);

   if_stage dut (
      .clk(clk), .rst_n(rst_n),
      .imem_addr(imem_addr), .imem_instr(imem_instr),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .id_valid(id_valid), .id_ready(id_ready),
      .id_pc(id_pc), .id_instr(id_instr), .misalign_err(misalign_err)
   );

   if_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
      .clk(clk), .rst_n(rst_n),
      .imem_addr(w_imem_addr), .imem_instr(w_imem_instr),
      .redirect_valid(1'b0), .redirect_pc(32'h0),
      .id_valid(w_id_valid), .id_ready(1'b1),
      .id_pc(w_id_pc), .id_instr(w_id_instr), .misalign_err(w_misalign_err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected architectural view after one clock edge.
   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] ipc;
      logic [31:0] instr;
      logic        mis;
   } exp_t;

   exp_t sb_q[$];
   bit   mon_en    = 1'b0;
   bit   first_rel = 1'b0;

   // Reference model: what fetch address comes next, and what sits in the IF/ID slot.
   logic        m_valid;
   logic [31:0] m_pc, m_ipc, m_instr;

   task automatic model_reset();
      m_valid = 1'b0;
      m_pc    = 32'h0;
      m_ipc   = 32'h0;
      m_instr = 32'h0000_0013;
   endtask

   // Drive one cycle's inputs (caller is already past the negedge) and predict the outcome.
   task automatic apply(input bit rdy, input bit rv, input logic [31:0] rpc);
      exp_t e;
      logic mis;
      id_ready       = rdy;
      redirect_valid = rv;
      redirect_pc    = rpc;
      mis = 1'b0;
      if (rv) begin
`ifdef IF_MISALIGN_CHK_EN
         mis  = (rpc % 4) != 0;
         m_pc = rpc - (rpc % 4);
`else
         m_pc = rpc;
`endif
         m_valid = 1'b0;
      end else if (!m_valid || rdy) begin
         m_ipc   = m_pc;
         m_instr = rom(m_pc);
         m_valid = 1'b1;
         m_pc    = m_pc + 32'd4;
      end
      e = '{valid: m_valid, pc: m_pc, ipc: m_ipc, instr: m_instr, mis: mis};
      sb_q.push_back(e);
   endtask

   task automatic drive(input bit rdy, input bit rv, input logic [31:0] rpc);
      @(negedge clk);
      #1;
      apply(rdy, rv, rpc);
   endtask

   task automatic drive_random(input int n);
      for (int i = 0; i < n; i++) begin
         logic [31:0] rpc;
         case ($urandom_range(0, 3))
            0:       rpc = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            1:       rpc = 32'($urandom_range(0, 1023));
            2:       rpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            default: rpc = $urandom;
         endcase
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, rpc);
      end
   endtask

   // Wait until the monitor has consumed the last prediction, then stop it.
   task automatic stop_monitor();
      @(posedge clk);
      #3;
      mon_en = 1'b0;
      check("sb_drained", 32'(sb_q.size()), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_id_valid"}, 32'(id_valid), 32'd0);
      check({tag, "_id_pc"}, id_pc, 32'h0);
      check({tag, "_id_instr"}, id_instr, 32'h0000_0013);
      check({tag, "_misalign"}, 32'(misalign_err), 32'd0);
      check({tag, "_imem_addr"}, imem_addr, 32'h0);
   endtask

   // Monitor: after every active edge, pop one prediction and compare the visible state.
   always begin : monitor
      exp_t e;
      @(posedge clk);
      #2;
      if (mon_en) begin
         if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_underflow: got empty queue expected a prediction at %0t", $time);
         end else begin
            e = sb_q.pop_front();
            check("id_valid", 32'(id_valid), 32'(e.valid));
            check("imem_addr", imem_addr, e.pc);
            check("id_pc", id_pc, e.ipc);
            check("id_instr", id_instr, e.instr);
            check("misalign_err", 32'(misalign_err), 32'(e.mis));
         end
      end
   end

   // Wraparound instance: free-running fetch from 0xFFFF_FFF8 crosses zero.
   initial begin : wrap_check
      logic [31:0] exp_pc;
      wait (first_rel);
      exp_pc = 32'hFFFF_FFF8;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #2;
         check("wrap_id_valid", 32'(w_id_valid), 32'd1);
         check("wrap_id_pc", w_id_pc, exp_pc);
         check("wrap_id_instr", w_id_instr, rom(exp_pc));
         check("wrap_misalign", 32'(w_misalign_err), 32'd0);
         exp_pc = exp_pc + 32'd4;
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      model_reset();
      #1;
      rst_n = 1'b0;
      #2;
      check_reset_outputs("reset");
      id_ready = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      check_reset_outputs("in_reset");

      // Release between edges; the very next edge must fetch RESET_PC.
      @(negedge clk);
      #1;
      rst_n     = 1'b1;
      first_rel = 1'b1;
      mon_en    = 1'b1;
      apply(1'b1, 1'b0, 32'h0);                  // 0 / 00100093
      drive(1'b1, 1'b0, 32'h0);                  // 4 / 00200113
      repeat (3) drive(1'b0, 1'b0, 32'h0);       // stall holding pc 4
      drive(1'b1, 1'b0, 32'h0);                  // 8 / 00300193, no skip
      drive(1'b0, 1'b0, 32'h0);                  // stalled at 8
      drive(1'b0, 1'b1, 32'h10);                 // redirect: bubble
      drive(1'b1, 1'b0, 32'h0);                  // 0x10 / 00500293
      drive(1'b1, 1'b1, 32'h0E);                 // misaligned redirect
      repeat (3) drive(1'b1, 1'b0, 32'h0);
      drive(1'b1, 1'b1, 32'hFFFF_FFFC);          // redirect next to the wrap point
      repeat (3) drive(1'b1, 1'b0, 32'h0);
      drive_random(400);

      // Asynchronous reset between edges must clear outputs immediately.
      stop_monitor();
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      rst_n  = 1'b1;
      mon_en = 1'b1;
      apply(1'b1, 1'b0, 32'h0);
      drive_random(300);
      stop_monitor();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
